// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcode encoding and small helpers for the arbitrated logic unit.
package logic_unit_arbiter_pkg;

    localparam int unsigned LOP_W = 3;

    localparam logic [LOP_W-1:0] LOP_AND  = 3'd0;
    localparam logic [LOP_W-1:0] LOP_OR   = 3'd1;
    localparam logic [LOP_W-1:0] LOP_NOR  = 3'd2;
    localparam logic [LOP_W-1:0] LOP_NAND = 3'd3;
    localparam logic [LOP_W-1:0] LOP_XOR  = 3'd4;
    localparam logic [LOP_W-1:0] LOP_XNOR = 3'd5;

    function automatic logic lop_legal(input logic [LOP_W-1:0] op);
        return (op <= LOP_XNOR);
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Combinational bitwise logic unit; illegal opcodes yield zero with err set.
module logic_unit_arbiter_logic_unit
    import logic_unit_arbiter_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [LOP_W-1:0] i_op,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic [W-1:0]     o_y,
    output logic             o_err
);

    always_comb begin
        o_y   = '0;
        o_err = !lop_legal(i_op);
        case (i_op)
            LOP_AND:  o_y = i_a & i_b;
            LOP_OR:   o_y = i_a | i_b;
            LOP_NOR:  o_y = ~(i_a | i_b);
            LOP_NAND: o_y = ~(i_a & i_b);
            LOP_XOR:  o_y = i_a ^ i_b;
            LOP_XNOR: o_y = ~(i_a ^ i_b);
            default:  o_y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit among N requesters, one registered result stage.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter  int unsigned N   = 4,
    parameter  int unsigned W   = 8,
    parameter  int unsigned CW  = 16,
    localparam int unsigned IDW = $clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N-1:0]     i_req_valid,
    output logic [N-1:0]     o_req_ready,
    input  logic [LOP_W*N-1:0] i_req_op,
    input  logic [W*N-1:0]   i_req_a,
    input  logic [W*N-1:0]   i_req_b,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [W-1:0]     o_rsp_data,
    output logic [IDW-1:0]   o_rsp_id,
    output logic             o_rsp_err,
    output logic [CW-1:0]    o_op_count
);

    logic [IDW-1:0]   r_ptr;
    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [IDW-1:0]   r_id;
    logic             r_err;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_grant_any;
    logic [IDW-1:0]   w_grant_idx;
    logic             w_fire;
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_scan;
    logic [LOP_W-1:0] w_op;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [W-1:0]     w_y;
    logic             w_err;

    assign w_accept = !r_valid || i_rsp_ready;

    // Scan upward from r_ptr with explicit wrap so non-power-of-two N works.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_scan      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(N)) begin
                w_sum = w_sum - (IDW+1)'(N);
            end
            w_scan = w_sum[IDW-1:0];
            if (!w_grant_any && i_req_valid[w_scan]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_scan;
            end
        end
    end

    assign w_fire = w_accept && w_grant_any;

    always_comb begin
        o_req_ready = '0;
        if (w_fire) begin
            o_req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_op = i_req_op[LOP_W*w_grant_idx +: LOP_W];
    assign w_a  = i_req_a[W*w_grant_idx +: W];
    assign w_b  = i_req_b[W*w_grant_idx +: W];

    logic_unit_arbiter_logic_unit #(
        .W (W)
    ) u_logic_unit (
        .i_op  (w_op),
        .i_a   (w_a),
        .i_b   (w_b),
        .o_y   (w_y),
        .o_err (w_err)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_data  <= w_y;
            r_id    <= w_grant_idx;
            r_err   <= w_err;
            r_ptr   <= (w_grant_idx == IDW'(N-1)) ? '0 : w_grant_idx + 1'b1;
        end else if (i_rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_fire && (r_cnt != {CW{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_rsp_valid = r_valid;
    assign o_rsp_data  = r_data;
    assign o_rsp_id    = r_id;
    assign o_rsp_err   = r_err;
    assign o_op_count  = r_cnt;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench: spec-level model compared every cycle, plus literal pins.
module tb_logic_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_ready_s;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_ready;
    logic           rsp_valid, rsp_valid_s;
    logic [W-1:0]   rsp_data, rsp_data_s;
    logic [1:0]     rsp_id, rsp_id_s;
    logic           rsp_err, rsp_err_s;
    logic [15:0]    op_count;
    logic [3:0]     op_count_s;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.N(N), .W(W), .CW(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_id    (rsp_id),
        .o_rsp_err   (rsp_err),
        .o_op_count  (op_count)
    );

    // Narrow-counter copy on the same stimulus to exercise saturation.
    logic_unit_arbiter #(.N(N), .W(W), .CW(4)) dut_sat (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready_s),
        .i_req_op    (req_op),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_rsp_valid (rsp_valid_s),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data_s),
        .o_rsp_id    (rsp_id_s),
        .o_rsp_err   (rsp_err_s),
        .o_op_count  (op_count_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] eval_y(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a | b);
            3'd3: return ~(a & b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_id;
    logic         m_err;
    int           m_ptr;
    int           m_cnt;
    int           m_g;
    logic         m_accept;
    logic [N-1:0] m_ready;

    always_comb begin
        m_g      = pick(req_valid, m_ptr);
        m_accept = !m_valid || rsp_ready;
        m_ready  = '0;
        if (m_accept && m_g >= 0) m_ready = N'(1) << m_g;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_id    <= 0;
            m_err   <= 1'b0;
            m_ptr   <= 0;
            m_cnt   <= 0;
        end else if (m_accept && m_g >= 0) begin
            m_valid <= 1'b1;
            m_data  <= eval_y(req_op[3*m_g +: 3], req_a[W*m_g +: W], req_b[W*m_g +: W]);
            m_err   <= (req_op[3*m_g +: 3] > 3'd5);
            m_id    <= m_g;
            m_ptr   <= (m_g + 1) % N;
            m_cnt   <= m_cnt + 1;
        end else if (rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("rsp_data",  32'(rsp_data),  32'(m_data));
        chk("rsp_id",    32'(rsp_id),    32'(m_id));
        chk("rsp_err",   32'(rsp_err),   32'(m_err));
        chk("op_count",  32'(op_count),  (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
        chk("sat_count", 32'(op_count_s), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
        chk("sat_ready", 32'(req_ready_s), 32'(m_ready));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]      = v;
        req_op[3*i +: 3]  = op;
        req_a[W*i +: W]   = a;
        req_b[W*i +: W]   = b;
    endtask

    logic [N-1:0] pats [8] = '{4'b1111, 4'b0101, 4'b1000, 4'b0000,
                               4'b0110, 4'b1011, 4'b0001, 4'b1110};
    logic [N-1:0] exp_grants [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // XOR from requester 0
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 3'd4, 8'hF0, 8'hAA);
        #1;
        chk("xor_ready", 32'(req_ready), 32'b0001);
        tick();
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        chk("xor_data", 32'(rsp_data), 32'h5A);
        chk("xor_id",   32'(rsp_id),   32'd0);
        chk("xor_err",  32'(rsp_err),  32'd0);
        chk("xor_valid", 32'(rsp_valid), 32'd1);

        // Hold a result under backpressure, then reset asynchronously.
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 3'd1, 8'h0F, 8'h30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_now", 32'(rsp_valid), 32'd0);
        chk("rst_count_now", 32'(op_count), 32'd0);
        tick();
        rst_n = 1'b1;

        // All four requesters valid continuously
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i), 8'(8'h11 * (i + 1)), 8'hC3);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(exp_grants[c]));
            tick();
        end
        chk("rr_count", 32'(op_count), 32'd5);
        chk("rr_last_id", 32'(rsp_id), 32'd0);

        // Backpressure with req1, req2 pending
        rsp_ready = 1'b0;
        set_req(0, 1'b0, 3'd0, 8'h00, 8'h00);
        set_req(3, 1'b0, 3'd0, 8'h00, 8'h00);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_id", 32'(rsp_id), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("drain_ready", 32'(req_ready), 32'b0010);
        tick();
        chk("drain_id", 32'(rsp_id), 32'd1);
        chk("drain_valid", 32'(rsp_valid), 32'd1);

        // Illegal and edge-case opcodes on requester 2
        set_req(1, 1'b0, 3'd0, 8'h00, 8'h00);
        set_req(2, 1'b1, 3'd6, 8'hFF, 8'hFF);
        tick();
        chk("ill_err",  32'(rsp_err),  32'd1);
        chk("ill_data", 32'(rsp_data), 32'h00);
        chk("ill_id",   32'(rsp_id),   32'd2);
        set_req(2, 1'b1, 3'd5, 8'h0F, 8'h0F);
        tick();
        chk("xnor_data", 32'(rsp_data), 32'hFF);
        chk("xnor_err",  32'(rsp_err),  32'd0);
        set_req(2, 1'b1, 3'd3, 8'hFF, 8'hFF);
        tick();
        chk("nand_data", 32'(rsp_data), 32'h00);

        // Mixed traffic with withdrawn requests and intermittent backpressure
        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, pats[c % 8][i], 3'((i + c) % 8), 8'(c * 17), 8'(i * 51 + c));
            end
            rsp_ready = (c % 3) != 0;
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        chk("sat_hold", 32'(op_count_s), 32'hF);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
